// File: rtl/if_id_buffer.sv
// Two-entry IF/ID skid buffer between fetch and decode.
// It keeps FIFO order, and flush discards all buffered and incoming instructions.
module if_id_buffer #(
  parameter int unsigned    WIDTH     = 16,
  parameter int unsigned    MEM_WIDTH = 8,
  parameter logic [WIDTH-1:0] NOP     = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_instr,
  input  logic [MEM_WIDTH-1:0] in_pc,
  input  logic                 in_valid,
  input  logic                 flush,
  input  logic                 id_stall,
  output logic [WIDTH-1:0]     out_instr,
  output logic [MEM_WIDTH-1:0] out_pc,
  output logic                 out_valid,
  output logic                 if_stall
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e               state_q;
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [WIDTH-1:0]     mem_instr_q [2];
  logic [MEM_WIDTH-1:0] mem_pc_q    [2];

  logic push;
  logic pop;

  assign if_stall  = (state_q == StFull);
  assign out_valid = (state_q != StEmpty);
  assign push      = in_valid & ~if_stall & ~flush;
  assign pop       = out_valid & ~id_stall & ~flush;

  assign out_instr = out_valid ? mem_instr_q[rd_ptr_q] : NOP;
  assign out_pc    = out_valid ? mem_pc_q[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StEmpty;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else if (flush) begin
      state_q  <= StEmpty;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      unique case (state_q)
        StEmpty: if (push) state_q <= StOne;
        StOne: begin
          if (push && !pop)      state_q <= StFull;
          else if (pop && !push) state_q <= StEmpty;
        end
        StFull:  if (pop) state_q <= StOne;
        default: state_q <= StEmpty;
      endcase
    end
  end

  // Storage is not reset; only the state decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_instr_q[wr_ptr_q] <= in_instr;
      mem_pc_q[wr_ptr_q]    <= in_pc;
    end
  end

endmodule
